// File: rtl/fma_writeback_buffer.sv
// fma_writeback_buffer: captures a full batch of FMA results in one cycle and
// drains the masked entries, lowest index first, over a valid/ready write port.
module fma_writeback_buffer #(
    parameter  int FMA_COUNT = 2,
    parameter  int WIDTH     = 16,
    localparam int IDX_W     = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     fma_result_in [FMA_COUNT-1:0],
    input  logic [FMA_COUNT-1:0] fma_write_mask_in,
    input  logic                 fma_result_valid_in,
    output logic                 busy_out,
    output logic [WIDTH-1:0]     wr_data_out,
    output logic [IDX_W-1:0]     wr_index_out,
    output logic                 wr_valid_out,
    input  logic                 wr_ready_in,
    output logic                 done_out,
    output logic                 overflow_out
);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cap_q [FMA_COUNT-1:0];
    logic [FMA_COUNT-1:0] pending_q;
    logic [FMA_COUNT-1:0] remaining;
    logic [WIDTH-1:0]     wr_data_q;
    logic [IDX_W-1:0]     wr_index_q;
    logic                 wr_valid_q;
    logic                 done_q;
    logic                 overflow_q;
    logic                 accept;
    logic                 handshake;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     next_idx;

    // Lowest set bit; scanning downward lets the last hit win.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [FMA_COUNT-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = FMA_COUNT - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Handshake qualifiers and the pending set left after the current word.
    always_comb begin
        accept    = (state_q == IDLE) && fma_result_valid_in;
        handshake = wr_valid_q && wr_ready_in;
        remaining = pending_q & ~(FMA_COUNT'(1) << wr_index_q);
        first_idx = lowest_set(fma_write_mask_in);
        next_idx  = lowest_set(remaining);
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: enter DRAIN on a non-empty batch, leave after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (fma_write_mask_in != '0)) state_d = DRAIN;
            DRAIN:   if (handshake && (remaining == '0))      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy is a pure state decode, write port comes from registers.
    always_comb begin
        busy_out     = (state_q == DRAIN);
        wr_data_out  = wr_data_q;
        wr_index_out = wr_index_q;
        wr_valid_out = wr_valid_q;
        done_out     = done_q;
        overflow_out = overflow_q;
    end

    // Capture, drain sequencing, done pulse and sticky overflow.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < FMA_COUNT; i++) cap_q[i] <= '0;
            pending_q  <= '0;
            wr_data_q  <= '0;
            wr_index_q <= '0;
            wr_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (fma_write_mask_in != '0) begin
                    for (int i = 0; i < FMA_COUNT; i++) cap_q[i] <= fma_result_in[i];
                    pending_q  <= fma_write_mask_in;
                    wr_index_q <= first_idx;
                    wr_data_q  <= fma_result_in[first_idx];
                    wr_valid_q <= 1'b1;
                end else begin
                    // Empty batch completes immediately.
                    done_q <= 1'b1;
                end
            end else if (state_q == DRAIN) begin
                if (fma_result_valid_in) overflow_q <= 1'b1;
                if (handshake) begin
                    pending_q <= remaining;
                    if (remaining != '0) begin
                        wr_index_q <= next_idx;
                        wr_data_q  <= cap_q[next_idx];
                    end else begin
                        wr_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
